// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg (package)
//  Description : Shared types and default constants for the traffic-light
//                interval timer. Holds the timer state encoding and the
//                default counter width / timeout / prescale values.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Interval timer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } timer_state_t;

  // Default parameter values
  localparam int C_N       = 11;
  localparam int C_T_SHORT = 5;
  localparam int C_T_LONG  = 25;
  localparam int C_DIV     = 10;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Modulo-DIV prescaler. Produces a one-clock tick enable every
//                DIV clocks. clr (and reset) return the count to 0, so the
//                first tick after a clear lands DIV clocks later.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous, active-low reset
//                clr   - synchronous clear of the prescale count
//                tick  - tick enable, high for one clock every DIV clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
  import traffic_pkg::*;
#(
  parameter int DIV = C_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int              C_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [C_W-1:0]  C_LAST = C_W'(DIV - 1);

  logic [C_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Decoded from the count flop; the tick is an internal enable only.
  assign tick = (r_cnt == C_LAST);

endmodule : tick_gen
`default_nettype wire

// File: rtl/traffic_timer.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_timer
//  Description : Interval timer for the traffic-light controller. ST restarts
//                the interval; TS / TL flag the short and long timeouts, and
//                the count saturates at 2^N-1 raising timeoff.
//                Optional macro TRAFFIC_TIMER_PRESCALE_EN: when defined, one
//                tick is DIV clocks (tick_gen prescaler); otherwise every clock
//                is a tick and DIV is ignored.
//  Ports       : clk     - rising-edge clock
//                reset   - synchronous, active-low reset
//                ST      - start/restart request
//                Timing  - current tick count (N bits)
//                TS      - short timeout reached (Timing >= T_SHORT)
//                TL      - long timeout reached  (Timing >= T_LONG)
//                timeoff - counter saturated at 2^N-1
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int N       = C_N,
  parameter int T_SHORT = C_T_SHORT,
  parameter int T_LONG  = C_T_LONG,
  parameter int DIV     = C_DIV
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ST,
  output logic [N-1:0] Timing,
  output logic         TS,
  output logic         TL,
  output logic         timeoff
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (N < 2 || N > 30) begin : g_bad_n
    $error("traffic_timer: N must be in 2..30");
  end
  if (T_SHORT < 1 || T_SHORT >= T_LONG) begin : g_bad_short
    $error("traffic_timer: need 1 <= T_SHORT < T_LONG");
  end
  if (T_LONG > (2**N) - 1) begin : g_bad_long
    $error("traffic_timer: need T_LONG <= 2^N-1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("traffic_timer: DIV must be >= 1");
  end

  localparam logic [N-1:0] C_MAX   = {N{1'b1}};
  localparam logic [N-1:0] C_SHORT = N'(T_SHORT);
  localparam logic [N-1:0] C_LONG  = N'(T_LONG);

  // --------------------------------------------------------------------------
  // Tick enable
  // --------------------------------------------------------------------------
  logic w_tick;

`ifdef TRAFFIC_TIMER_PRESCALE_EN
  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (ST),
    .tick  (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  timer_state_t r_state,  w_state_nxt;
  logic [N-1:0] r_timing, w_timing_nxt;
  logic         r_ts,     w_ts_nxt;
  logic         r_tl,     w_tl_nxt;
  logic         r_toff,   w_toff_nxt;
  logic [N-1:0] w_inc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_timing <= '0;
      r_ts     <= 1'b0;
      r_tl     <= 1'b0;
      r_toff   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timing <= w_timing_nxt;
      r_ts     <= w_ts_nxt;
      r_tl     <= w_tl_nxt;
      r_toff   <= w_toff_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // The flags are computed from the value being loaded into Timing so they
  // change on the same edge as the count.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_timing_nxt = r_timing;
    w_ts_nxt     = r_ts;
    w_tl_nxt     = r_tl;
    w_toff_nxt   = r_toff;
    w_inc        = r_timing + 1'b1;

    case (r_state)
      IDLE: begin
        w_timing_nxt = '0;
        w_ts_nxt     = 1'b0;
        w_tl_nxt     = 1'b0;
        w_toff_nxt   = 1'b0;
        if (ST) begin
          w_state_nxt = RUN;
        end
      end

      RUN: begin
        if (ST) begin
          w_timing_nxt = '0;
          w_ts_nxt     = 1'b0;
          w_tl_nxt     = 1'b0;
          w_toff_nxt   = 1'b0;
        end else if (w_tick) begin
          w_timing_nxt = w_inc;
          w_ts_nxt     = (w_inc >= C_SHORT);
          w_tl_nxt     = (w_inc >= C_LONG);
          if (w_inc == C_MAX) begin
            w_state_nxt = SAT;
            w_toff_nxt  = 1'b1;
          end
        end
      end

      SAT: begin
        if (ST) begin
          w_state_nxt  = RUN;
          w_timing_nxt = '0;
          w_ts_nxt     = 1'b0;
          w_tl_nxt     = 1'b0;
          w_toff_nxt   = 1'b0;
        end else begin
          w_timing_nxt = C_MAX;
          w_toff_nxt   = 1'b1;
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_timing_nxt = '0;
        w_ts_nxt     = 1'b0;
        w_tl_nxt     = 1'b0;
        w_toff_nxt   = 1'b0;
      end
    endcase
  end

  assign Timing  = r_timing;
  assign TS      = r_ts;
  assign TL      = r_tl;
  assign timeoff = r_toff;

endmodule : traffic_timer
`default_nettype wire

// File: tb/tb_traffic_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_timer
//  Description : Self-checking bench for traffic_timer. A cycle-level
//                reference model pushes the expected outputs into a
//                scoreboard queue every clock; a table of checkpoints with
//                hand-derived values is checked at the end of each segment.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_timer;

  localparam int N       = 11;
  localparam int T_SHORT = 5;
  localparam int T_LONG  = 25;
  localparam int DIV     = 10;
  localparam int MAXV    = (2**N) - 1;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         st    = 1'b0;
  logic [N-1:0] timing;
  logic         ts;
  logic         tl;
  logic         toff;

  always #5 clk = ~clk;

  traffic_timer #(
    .N       (N),
    .T_SHORT (T_SHORT),
    .T_LONG  (T_LONG),
    .DIV     (DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ST      (st),
    .Timing  (timing),
    .TS      (ts),
    .TL      (tl),
    .timeoff (toff)
  );

  typedef struct {
    bit           rst_n;
    bit           st;
    int           cycles;
    logic [N-1:0] t;
    bit           ts;
    bit           tl;
    bit           to;
  } vec_t;

  typedef struct {
    logic [N-1:0] t;
    bit           ts;
    bit           tl;
    bit           to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 idle, 1 counting, 2 saturated
  int m_t     = 0;
  int m_state = 0;
  int m_pre   = 0;

  task automatic add(input bit r, input bit s, input int c, input int t,
                     input bit a, input bit b, input bit d);
    vec_t v;
    v.rst_n  = r;
    v.st     = s;
    v.cycles = c;
    v.t      = N'(t);
    v.ts     = a;
    v.tl     = b;
    v.to     = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input exp_t e);
    n_checks++;
    if (timing !== e.t || ts !== e.ts || tl !== e.tl || toff !== e.to) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @%0t: got Timing=%0d TS=%b TL=%b timeoff=%b, expected Timing=%0d TS=%b TL=%b timeoff=%b",
                 name, $time, timing, ts, tl, toff, e.t, e.ts, e.tl, e.to);
    end
  endtask

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_step(input bit r, input bit s);
    bit   tick;
    exp_t e;
`ifdef TRAFFIC_TIMER_PRESCALE_EN
    tick = (m_pre == DIV - 1);
    if (!r || s)  m_pre = 0;
    else if (tick) m_pre = 0;
    else          m_pre = m_pre + 1;
`else
    tick = 1'b1;
`endif
    if (!r) begin
      m_t     = 0;
      m_state = 0;
    end else if (s) begin
      m_t     = 0;
      m_state = 1;
    end else if (m_state == 1 && tick) begin
      m_t = m_t + 1;
      if (m_t == MAXV) m_state = 2;
    end
    e.t  = N'(m_t);
    e.ts = (m_state != 0) && (m_t >= T_SHORT);
    e.tl = (m_state != 0) && (m_t >= T_LONG);
    e.to = (m_state == 2);
    sb.push_back(e);
  endtask

  // One clock: drive at the falling edge, compare scoreboard 1 ns after rise.
  task automatic cycle(input bit r, input bit s);
    exp_t e;
    reset = r;
    st    = s;
    @(posedge clk);
    model_step(r, s);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty @%0t", $time);
    end else begin
      e = sb.pop_front();
      check("scoreboard", e);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;

`ifndef TRAFFIC_TIMER_PRESCALE_EN
    // rst st cycles | Timing TS TL timeoff
    add(0, 0,    1,    0, 0, 0, 0);   // reset
    add(1, 0,   20,    0, 0, 0, 0);   // idle without ST
    add(1, 1,    1,    0, 0, 0, 0);   // ST at edge k
    add(1, 0,    4,    4, 0, 0, 0);
    add(1, 0,    1,    5, 1, 0, 0);   // TS after k+5
    add(1, 0,   19,   24, 1, 0, 0);
    add(1, 0,    1,   25, 1, 1, 0);   // TL after k+25
    add(1, 0,    5,   30, 1, 1, 0);   // flags stay high
    add(1, 1,    1,    0, 0, 0, 0);   // restart
    add(1, 0,   10,   10, 1, 0, 0);
    add(1, 1,    1,    0, 0, 0, 0);   // second ST at k+10
    add(1, 0,    4,    4, 0, 0, 0);
    add(1, 0,    1,    5, 1, 0, 0);   // TS again after k+15
    add(1, 1,    1,    0, 0, 0, 0);
    add(1, 0, 2046, 2046, 1, 1, 0);
    add(1, 0,    1, 2047, 1, 1, 1);   // saturation at k+2047
    add(1, 0,   50, 2047, 1, 1, 1);   // holds
    add(1, 1,    1,    0, 0, 0, 0);   // ST leaves SAT
    add(1, 1,    7,    0, 0, 0, 0);   // ST held 8 cycles
    add(1, 0,   12,   12, 1, 0, 0);
    add(0, 0,    1,    0, 0, 0, 0);   // reset mid-interval
    add(1, 0,    5,    0, 0, 0, 0);   // back in IDLE: no counting
    add(1, 1,    1,    0, 0, 0, 0);
    add(1, 0,    3,    3, 0, 0, 0);
    add(0, 1,    1,    0, 0, 0, 0);   // reset beats ST
    add(1, 0,    3,    0, 0, 0, 0);   // stayed in IDLE
`else
    add(0, 0,    1,    0, 0, 0, 0);
    add(1, 0,   20,    0, 0, 0, 0);
    add(1, 1,    1,    0, 0, 0, 0);   // ST at edge k
    add(1, 0,    9,    0, 0, 0, 0);
    add(1, 0,    1,    1, 0, 0, 0);   // first tick at k+DIV
    add(1, 0,   39,    4, 0, 0, 0);
    add(1, 0,    1,    5, 1, 0, 0);   // TS at k+50
    add(1, 0,  199,   24, 1, 0, 0);
    add(1, 0,    1,   25, 1, 1, 0);   // TL at k+250
    add(1, 1,    1,    0, 0, 0, 0);   // restart clears prescaler
    add(1, 0,    9,    0, 0, 0, 0);
    add(1, 0,    1,    1, 0, 0, 0);
    add(0, 0,    1,    0, 0, 0, 0);
`endif

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) cycle(vecs[i].rst_n, vecs[i].st);
      e.t  = vecs[i].t;
      e.ts = vecs[i].ts;
      e.tl = vecs[i].tl;
      e.to = vecs[i].to;
      check($sformatf("vec%0d", i), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_traffic_timer
`default_nettype wire
